// File: rtl/mano_timing_ctrl_pkg.sv
// Shared constants, opcode encoding and decode helper for the basic-computer timing control stage.
package mano_ctrl_pkg;

    localparam int T_NUM_DEF = 6;
    localparam int SC_W_DEF  = 3;

    typedef enum logic [2:0] {
        OP_AND = 3'd0,
        OP_ADD = 3'd1,
        OP_LDA = 3'd2,
        OP_STA = 3'd3,
        OP_BUN = 3'd4,
        OP_BSA = 3'd5,
        OP_ISZ = 3'd6,
        OP_RIO = 3'd7
    } opcode_t;

    typedef enum logic {
        ST_HALT = 1'b0,
        ST_RUN  = 1'b1
    } run_st_t;

    function automatic logic [7:0] onehot8(input logic [2:0] sel);
        logic [7:0] v;
        v = '0;
        v[sel] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/mano_timing_ctrl_if.sv
// Control-stage bus: run/halt/clear controls and opcode in, timing/decode outputs back.
// Carries SSTEP only when MANO_SINGLE_STEP_EN is defined.
interface mano_timing_ctrl_if #(
    parameter int T_NUM = mano_ctrl_pkg::T_NUM_DEF
);
    logic             START;
    logic             HLT;
    logic             SC_CLR;
    logic [3:0]       OP;
`ifdef MANO_SINGLE_STEP_EN
    logic             SSTEP;
`endif
    logic [T_NUM-1:0] T;
    logic [7:0]       D;
    logic             J;
    logic             S;
    logic             SEQ_ERR;

    modport master (
`ifdef MANO_SINGLE_STEP_EN
        output SSTEP,
`endif
        output START, HLT, SC_CLR, OP,
        input  T, D, J, S, SEQ_ERR
    );

    modport slave (
`ifdef MANO_SINGLE_STEP_EN
        input  SSTEP,
`endif
        input  START, HLT, SC_CLR, OP,
        output T, D, J, S, SEQ_ERR
    );
endinterface

// File: rtl/mano_timing_ctrl_seq_counter.sv
// Sequence counter SC with clear/increment/wrap, sticky wrap fault, and S-gated one-hot T decode.
module mano_seq_counter #(
    parameter int T_NUM = 6,
    parameter int SC_W  = 3
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_s,
    input  logic             i_clr,
    output logic [T_NUM-1:0] o_t,
    output logic             o_seq_err
);
    localparam logic [SC_W-1:0] SC_LAST = SC_W'(T_NUM - 1);

    logic [SC_W-1:0] r_sc;
    logic            r_err;

    // Reaching the last state without an end-of-instruction clear is a fault, but execution continues.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sc  <= '0;
            r_err <= 1'b0;
        end else if (i_clr) begin
            r_sc  <= '0;
        end else if (r_sc == SC_LAST) begin
            r_sc  <= '0;
            r_err <= 1'b1;
        end else begin
            r_sc  <= r_sc + 1'b1;
        end
    end

    for (genvar k = 0; k < T_NUM; k++) begin : g_t
        assign o_t[k] = i_s && (r_sc == SC_W'(k));
    end

    assign o_seq_err = r_err;
endmodule

// File: rtl/mano_timing_ctrl.sv
// Timing control top: start/stop flip-flop S, opcode/indirect latch, and SC priority steering.
// Optional single-step halt after each instruction under MANO_SINGLE_STEP_EN.
module mano_timing_ctrl
    import mano_ctrl_pkg::*;
#(
    parameter int T_NUM = T_NUM_DEF,
    parameter int SC_W  = SC_W_DEF
) (
    input  logic                CLK,
    input  logic                RST,
    mano_timing_ctrl_if.slave   bus
);
    run_st_t          r_st;
    run_st_t          w_st_nxt;
    logic [7:0]       r_d;
    logic             r_j;
    logic             w_s;
    logic             w_sstep;
    logic             w_sc_clr;
    logic [T_NUM-1:0] w_t;
    logic             w_seq_err;

`ifdef MANO_SINGLE_STEP_EN
    assign w_sstep = bus.SSTEP;
`else
    assign w_sstep = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RST) r_st <= ST_HALT;
        else     r_st <= w_st_nxt;
    end

    always_comb begin
        w_st_nxt = r_st;
        case (r_st)
            ST_HALT: if (!bus.HLT && bus.START)      w_st_nxt = ST_RUN;
            ST_RUN:  if (bus.HLT)                    w_st_nxt = ST_HALT;
                     else if (bus.SC_CLR && w_sstep) w_st_nxt = ST_HALT;
            default:                                 w_st_nxt = ST_HALT;
        endcase
    end

    always_comb begin
        w_s         = (r_st == ST_RUN);
        bus.S       = w_s;
        bus.T       = w_t;
        bus.D       = r_d;
        bus.J       = r_j;
        bus.SEQ_ERR = w_seq_err;
    end

    // Halted keeps SC parked at 0, so START lands directly in T0.
    assign w_sc_clr = !w_s || bus.HLT || bus.SC_CLR;

    mano_seq_counter #(
        .T_NUM (T_NUM),
        .SC_W  (SC_W)
    ) u_sc (
        .i_clk     (CLK),
        .i_rst     (RST),
        .i_s       (w_s),
        .i_clr     (w_sc_clr),
        .o_t       (w_t),
        .o_seq_err (w_seq_err)
    );

    // Opcode and I are captured at the end of T1 and held until the next fetch.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_d <= 8'h00;
            r_j <= 1'b0;
        end else if (w_t[1]) begin
            r_d <= onehot8(bus.OP[2:0]);
            r_j <= bus.OP[3];
        end
    end
endmodule

// File: tb/tb_mano_timing_ctrl.sv
// Directed test-plan sequences plus random stimulus against a behavioural model of the timing stage.
module tb_mano_timing_ctrl;
    import mano_ctrl_pkg::*;

    localparam int TN = T_NUM_DEF;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    mano_timing_ctrl_if #(.T_NUM(TN)) bus ();

    mano_timing_ctrl #(.T_NUM(TN), .SC_W(SC_W_DEF)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    int n_chk = 0;
    int n_err = 0;

    int         m_sc  = 0;
    bit         m_s   = 1'b0;
    bit         m_j   = 1'b0;
    bit         m_err = 1'b0;
    logic [7:0] m_d   = 8'h00;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, advance the model across the edge, then compare all outputs.
    task automatic step(input bit rst, input bit st, input bit hl, input bit cl,
                        input logic [3:0] op, input bit ss);
        bit eff_ss;
        RST        = rst;
        bus.START  = st;
        bus.HLT    = hl;
        bus.SC_CLR = cl;
        bus.OP     = op;
`ifdef MANO_SINGLE_STEP_EN
        bus.SSTEP  = ss;
        eff_ss     = ss;
`else
        eff_ss     = 1'b0 & ss;
`endif
        @(posedge CLK);
        if (rst) begin
            m_s = 0; m_sc = 0; m_d = 8'h00; m_j = 0; m_err = 0;
        end else begin
            if (m_s && m_sc == 1) begin
                m_d = 8'h00;
                m_d[op[2:0]] = 1'b1;
                m_j = op[3];
            end
            if (hl) begin
                m_s = 0; m_sc = 0;
            end else if (!m_s) begin
                if (st) m_s = 1;
                m_sc = 0;
            end else if (cl) begin
                m_sc = 0;
                if (eff_ss) m_s = 0;
            end else if (m_sc == TN - 1) begin
                m_sc = 0; m_err = 1;
            end else begin
                m_sc = m_sc + 1;
            end
        end
        @(negedge CLK);
        chk("T",       32'(bus.T),       m_s ? (32'd1 << m_sc) : 32'd0);
        chk("D",       32'(bus.D),       32'(m_d));
        chk("J",       32'(bus.J),       32'(m_j));
        chk("S",       32'(bus.S),       32'(m_s));
        chk("SEQ_ERR", 32'(bus.SEQ_ERR), 32'(m_err));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 4'h0, 0);
    endtask

    initial begin
        bus.START = 0; bus.HLT = 0; bus.SC_CLR = 0; bus.OP = 4'h0;
`ifdef MANO_SINGLE_STEP_EN
        bus.SSTEP = 0;
`endif
        step(1, 0, 0, 0, 4'h0, 0);
        step(1, 1, 0, 1, 4'hF, 0);
        chk("rst_T", 32'(bus.T), 0);
        chk("rst_S", 32'(bus.S), 0);
        chk("rst_D", 32'(bus.D), 0);

        idle(1);
        step(0, 1, 0, 0, 4'h0, 0);
        chk("start_T0", 32'(bus.T), 32'h01);
        step(0, 0, 0, 0, 4'h0, 0);
        chk("T1", 32'(bus.T), 32'h02);
        chk("preD", 32'(bus.D), 0);
        chk("preJ", 32'(bus.J), 0);
        step(0, 0, 0, 0, 4'b1010, 0);
        chk("T2", 32'(bus.T), 32'h04);
        chk("dec_D", 32'(bus.D), 32'h04);
        chk("dec_J", 32'(bus.J), 1);
        idle(2);
        chk("T4", 32'(bus.T), 32'h10);
        step(0, 0, 0, 1, 4'h3, 0);
        chk("clr_T0", 32'(bus.T), 32'h01);
        chk("clr_D", 32'(bus.D), 32'h04);
        chk("clr_J", 32'(bus.J), 1);

        for (int i = 0; i < TN; i++) step(0, 0, 0, 0, 4'h6, 0);
        chk("wrap_T", 32'(bus.T), 32'h01);
        chk("wrap_err", 32'(bus.SEQ_ERR), 1);
        idle(2);
        chk("err_sticky", 32'(bus.SEQ_ERR), 1);
        step(1, 0, 0, 0, 4'h0, 0);
        chk("rst_err", 32'(bus.SEQ_ERR), 0);

        step(0, 1, 0, 0, 4'h0, 0);
        idle(3);
        chk("T3", 32'(bus.T), 32'h08);
        step(0, 0, 1, 1, 4'h0, 0);
        chk("hlt_S", 32'(bus.S), 0);
        chk("hlt_T", 32'(bus.T), 0);
        idle(1);
        step(0, 1, 0, 0, 4'h0, 0);
        chk("resume_T0", 32'(bus.T), 32'h01);

        idle(2);
        step(1, 0, 0, 0, 4'hF, 0);
        chk("midrst_D", 32'(bus.D), 0);
        chk("midrst_T", 32'(bus.T), 0);
        idle(1);
        chk("midrst_S", 32'(bus.S), 0);
        step(0, 1, 0, 0, 4'h0, 0);
        chk("midrst_T0", 32'(bus.T), 32'h01);

`ifdef MANO_SINGLE_STEP_EN
        idle(3);
        step(0, 0, 0, 1, 4'h0, 1);
        chk("sstep_S", 32'(bus.S), 0);
        step(0, 1, 0, 0, 4'h0, 0);
        idle(3);
        step(0, 0, 0, 1, 4'h0, 0);
        chk("nostep_S", 32'(bus.S), 1);
        chk("nostep_T", 32'(bus.T), 32'h01);
`endif

        for (int i = 0; i < 3000; i++) begin
            step(($urandom % 64) == 0, ($urandom % 4) == 0, ($urandom % 16) == 0,
                 ($urandom % 5) == 0, 4'($urandom), ($urandom % 3) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
